// File: rtl/fetch_pc_sched.sv
// fetch_pc_sched: arbitrates EX/ID/BTB/sequential next-PC sources into the registered FS1 fetch PC
// and sequences the redirect protocol (flushes, one-cycle recovery bubble, held ID redirects).
module fetch_pc_sched #(
    parameter int SIZE_PC = 32,
    parameter logic [SIZE_PC-1:0] RESET_PC = '0,
    parameter int BUNDLE_BYTES = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               ctiQueueFull_i,
    input  logic               icacheReady_i,
    input  logic               exRedirect_i,
    input  logic [SIZE_PC-1:0] exTarget_i,
    input  logic               idRedirect_i,
    input  logic [SIZE_PC-1:0] idTarget_i,
    input  logic               btbTaken_i,
    input  logic [SIZE_PC-1:0] btbTarget_i,
    output logic [SIZE_PC-1:0] pc_o,
    output logic               fetchValid_o,
    output logic               flushFs1_o,
    output logic               flushFs2_o,
    output logic               recoverFlag_o,
    output logic [CNT_W-1:0]   redirectCnt_o
);
    typedef enum logic [1:0] {BOOT, RUN, BUBBLE} fetchState_e;

    fetchState_e       state;
    logic              pendValid;
    logic [SIZE_PC-1:0] pendTarget;
    logic              adv, idUse, pendUse, applied;
    logic [SIZE_PC-1:0] nextPc;

    // fetchValid_o is only high in RUN, so adv already implies RUN
    assign adv     = fetchValid_o & ~stall_i & ~ctiQueueFull_i & icacheReady_i;
    assign idUse   = idRedirect_i & adv;
    assign pendUse = pendValid & adv;
    assign applied = exRedirect_i | idUse | pendUse;

    assign flushFs2_o = reset & exRedirect_i;
    assign flushFs1_o = reset & applied;

    assign nextPc = idUse ? idTarget_i :
                    pendUse ? pendTarget :
                    (btbTaken_i & adv) ? btbTarget_i :
                    adv ? pc_o + SIZE_PC'(BUNDLE_BYTES) : pc_o;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= BOOT;
            pc_o          <= RESET_PC;
            fetchValid_o  <= 1'b0;
            recoverFlag_o <= 1'b0;
            redirectCnt_o <= '0;
            pendValid     <= 1'b0;
            pendTarget    <= '0;
        end else begin
            recoverFlag_o <= exRedirect_i;
            if (applied && !(&redirectCnt_o))
                redirectCnt_o <= redirectCnt_o + CNT_W'(1);
            if (exRedirect_i) begin
                state        <= BUBBLE;
                pc_o         <= exTarget_i;
                fetchValid_o <= 1'b0;
                pendValid    <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        pc_o <= nextPc;
                        if (adv) begin
                            pendValid <= 1'b0;
                        end else if (idRedirect_i) begin
                            pendValid  <= 1'b1;
                            pendTarget <= idTarget_i;
                        end
                    end
                    default: begin
                        state        <= RUN;
                        fetchValid_o <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_sched.sv
// tb_fetch_pc_sched: directed plus randomized checks of fetch_pc_sched against a cycle-level reference model.
module tb_fetch_pc_sched;
    logic        clk = 0;
    logic        reset;
    logic        stall, full, ready, ex, id, btb;
    logic [31:0] exT, idT, btbT;
    logic [31:0] pc, pc2;
    logic        valid, valid2, f1, f1b, f2, f2b, rec, rec2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int nChecks = 0;
    int nFail   = 0;

    // reference model state
    logic [31:0] mPc, mPendT;
    bit          mValid, mRec, mPendV, mWaitOne;
    int          mCnt, mCnt2;
    bit          lastF1;

    always #5 clk = ~clk;

    fetch_pc_sched dut (
        .clk(clk), .reset(reset), .stall_i(stall), .ctiQueueFull_i(full), .icacheReady_i(ready),
        .exRedirect_i(ex), .exTarget_i(exT), .idRedirect_i(id), .idTarget_i(idT),
        .btbTaken_i(btb), .btbTarget_i(btbT), .pc_o(pc), .fetchValid_o(valid),
        .flushFs1_o(f1), .flushFs2_o(f2), .recoverFlag_o(rec), .redirectCnt_o(cnt)
    );

    fetch_pc_sched #(.CNT_W(2)) dutSmall (
        .clk(clk), .reset(reset), .stall_i(stall), .ctiQueueFull_i(full), .icacheReady_i(ready),
        .exRedirect_i(ex), .exTarget_i(exT), .idRedirect_i(id), .idTarget_i(idT),
        .btbTaken_i(btb), .btbTarget_i(btbT), .pc_o(pc2), .fetchValid_o(valid2),
        .flushFs1_o(f1b), .flushFs2_o(f2b), .recoverFlag_o(rec2), .redirectCnt_o(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check the combinational flushes mid-cycle, advance the model, check registers after the edge.
    task automatic cyc();
        bit go, eF1, eF2;
        #2;
        go  = mValid && !stall && !full && ready;
        eF2 = reset && ex;
        eF1 = reset && (ex || (go && (id || mPendV)));
        lastF1 = f1;
        check("flushFs1", {31'b0, f1}, {31'b0, eF1});
        check("flushFs2", {31'b0, f2}, {31'b0, eF2});
        @(posedge clk);
        if (!reset) begin
            mPc = 32'h0; mValid = 0; mRec = 0; mCnt = 0; mCnt2 = 0; mPendV = 0; mWaitOne = 1;
        end else begin
            mRec = ex;
            if (ex || (go && (id || mPendV))) begin
                mCnt  = (mCnt  < 65535) ? mCnt + 1  : mCnt;
                mCnt2 = (mCnt2 < 3)     ? mCnt2 + 1 : mCnt2;
            end
            if (ex) begin
                mPc = exT; mValid = 0; mPendV = 0; mWaitOne = 1;
            end else if (mWaitOne) begin
                mValid = 1; mWaitOne = 0;
            end else if (go) begin
                if (id)          mPc = idT;
                else if (mPendV) mPc = mPendT;
                else if (btb)    mPc = btbT;
                else             mPc = mPc + 32'd32;
                mPendV = 0;
            end else if (id) begin
                mPendV = 1; mPendT = idT;
            end
        end
        #1;
        check("pc", pc, mPc);
        check("pcSmall", pc2, mPc);
        check("fetchValid", {31'b0, valid}, {31'b0, mValid});
        check("recoverFlag", {31'b0, rec}, {31'b0, mRec});
        check("redirectCnt", {16'b0, cnt}, mCnt);
        check("redirectCntSmall", {30'b0, cnt2}, mCnt2);
    endtask

    task automatic idle();
        ex = 0; id = 0; btb = 0; stall = 0; full = 0; ready = 1;
    endtask

    initial begin
        idle();
        exT = 0; idT = 0; btbT = 0;
        mPendT = 0; mPc = 0; mValid = 0; mRec = 0; mCnt = 0; mCnt2 = 0; mPendV = 0; mWaitOne = 1;
        reset = 0;
        #1;
        cyc();
        ex = 1; exT = 32'h1234_0000;   // reset must win over a simultaneous redirect
        cyc();
        check("resetPc", pc, 32'h0);
        check("resetValid", {31'b0, valid}, 32'h0);
        check("resetCnt", {16'b0, cnt}, 32'h0);

        // release reset: BOOT cycle, then sequential fetch
        idle(); reset = 1;
        cyc();
        check("bootExit valid", {31'b0, valid}, 32'h1);
        check("bootExit pc", pc, 32'h0);
        cyc(); check("seq 0x20", pc, 32'h20);
        cyc(); check("seq 0x40", pc, 32'h40);

        // BTB taken
        btb = 1; btbT = 32'h400;
        cyc();
        check("btb pc", pc, 32'h400);
        check("btb noFlush", {31'b0, lastF1}, 32'h0);
        check("btb cnt", {16'b0, cnt}, 32'h0);
        idle();

        // EX under stall with simultaneous ID
        stall = 1; ex = 1; exT = 32'h1000; id = 1; idT = 32'h2000;
        cyc();
        check("ex pc", pc, 32'h1000);
        check("ex valid", {31'b0, valid}, 32'h0);
        check("ex recover", {31'b0, rec}, 32'h1);
        check("ex cnt", {16'b0, cnt}, 32'h1);
        idle();
        cyc();
        check("bubbleEnd valid", {31'b0, valid}, 32'h1);
        check("bubbleEnd recover", {31'b0, rec}, 32'h0);

        // held ID, overwritten by a newer one, applied on release
        stall = 1; id = 1; idT = 32'h200;
        cyc();
        idT = 32'h300;
        cyc();
        id = 0;
        cyc(); cyc(); cyc();
        check("held pcHold", pc, 32'h1000);
        stall = 0;
        cyc();
        check("held flushRelease", {31'b0, lastF1}, 32'h1);
        check("held pc", pc, 32'h300);
        cyc();
        check("held flushOnce", {31'b0, lastF1}, 32'h0);

        // pending ID killed by EX
        stall = 1; id = 1; idT = 32'h500;
        cyc();
        id = 0; ex = 1; exT = 32'h800;
        cyc();
        check("kill pc", pc, 32'h800);
        idle();
        cyc(); cyc();
        check("kill seq", pc, 32'h820);

        // PC wrap
        ex = 1; exT = 32'hFFFF_FFE0;
        cyc();
        idle();
        cyc(); cyc();
        check("wrap pc", pc, 32'h0);

        // saturation of the narrow counter from a clean reset
        reset = 0; cyc(); reset = 1; cyc();
        for (int i = 0; i < 5; i++) begin
            ex = 1; exT = 32'h40 * i;
            cyc();
        end
        idle();
        check("sat small", {30'b0, cnt2}, 32'h3);
        check("sat wide", {16'b0, cnt}, 32'h5);
        cyc();

        // reset in the cycle of an EX redirect
        reset = 0; ex = 1; exT = 32'h9000;
        cyc();
        check("rstEx pc", pc, 32'h0);
        check("rstEx valid", {31'b0, valid}, 32'h0);
        check("rstEx recover", {31'b0, rec}, 32'h0);
        idle(); reset = 1;

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) >= 2);
            ex    = ($urandom_range(0, 99) < 8);
            id    = ($urandom_range(0, 99) < 15);
            btb   = ($urandom_range(0, 99) < 20);
            stall = ($urandom_range(0, 99) < 25);
            full  = ($urandom_range(0, 99) < 10);
            ready = ($urandom_range(0, 99) < 85);
            exT   = $urandom;
            idT   = $urandom;
            btbT  = $urandom;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
